// File: rtl/internet_mux_arbiter.sv
// rtl/internet_mux_arbiter.sv - four-source round-robin merge onto muxOutput with Sel tag; LIB_PRIORITY_EN gives Lib priority
module internet_mux_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Lib,
    input  logic [WIDTH-1:0] FD,
    input  logic [WIDTH-1:0] School,
    input  logic [WIDTH-1:0] Ribs,
    input  logic [3:0]       src_valid,
    output logic [3:0]       src_ready,
    output logic [WIDTH-1:0] muxOutput,
    output logic [1:0]       Sel,
    output logic             Enable,
    input  logic             out_ready
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t           state_q;
    logic [1:0]       owner_q;
    logic [1:0]       last_owner_q;
    logic [7:0]       beat_cnt_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic             en_q;
`ifdef LIB_PRIORITY_EN
    logic [1:0]       last_other_q;
`endif

    logic [WIDTH-1:0] owner_data;
    logic             can_accept;
    logic             xfer;
    logic [1:0]       pick;

    // First requester strictly after 'last', wrapping through 'last' itself.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        owner_data = Lib;
        case (owner_q)
            2'd0: owner_data = Lib;
            2'd1: owner_data = FD;
            2'd2: owner_data = School;
            2'd3: owner_data = Ribs;
        endcase
    end

    assign can_accept = !en_q || out_ready;
    assign xfer       = (state_q == GRANT) && src_valid[owner_q] && can_accept;
    assign src_ready  = ((state_q == GRANT) && can_accept) ? (4'b0001 << owner_q) : 4'b0000;

`ifdef LIB_PRIORITY_EN
    // Lib yields only right after its own burst, so the others each get a turn between Lib bursts.
    always_comb begin
        pick = 2'd0;
        if (src_valid[0] && ((last_owner_q != 2'd0) || (src_valid[3:1] == 3'b000)))
            pick = 2'd0;
        else
            pick = rr_pick({src_valid[3:1], 1'b0}, last_other_q);
    end
`else
    always_comb begin
        pick = rr_pick(src_valid, last_owner_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 2'd0;
            last_owner_q <= 2'd3;
            beat_cnt_q   <= 8'd0;
            data_q       <= '0;
            sel_q        <= 2'd0;
            en_q         <= 1'b0;
`ifdef LIB_PRIORITY_EN
            last_other_q <= 2'd3;
`endif
        end else begin
            if (xfer) begin
                data_q <= owner_data;
                sel_q  <= owner_q;
                en_q   <= 1'b1;
            end else if (out_ready) begin
                en_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (|src_valid) begin
                        owner_q    <= pick;
                        beat_cnt_q <= 8'd0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if ((xfer && (beat_cnt_q == LAST_BEAT)) || !src_valid[owner_q]) begin
                        last_owner_q <= owner_q;
`ifdef LIB_PRIORITY_EN
                        if (owner_q != 2'd0)
                            last_other_q <= owner_q;
`endif
                        state_q <= IDLE;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign muxOutput = data_q;
    assign Sel       = sel_q;
    assign Enable    = en_q;

endmodule

// File: tb/tb_internet_mux_arbiter.sv
// tb/tb_internet_mux_arbiter.sv - directed-vector bench for internet_mux_arbiter
module tb_internet_mux_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Lib, FD, School, Ribs;
    logic [3:0] src_valid;
    logic [3:0] src_ready;
    logic [3:0] muxOutput;
    logic [1:0] Sel;
    logic       Enable;
    logic       out_ready;

    int vectors     = 0;
    int miscompares = 0;

    internet_mux_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .Lib(Lib), .FD(FD), .School(School), .Ribs(Ribs),
        .src_valid(src_valid), .src_ready(src_ready),
        .muxOutput(muxOutput), .Sel(Sel), .Enable(Enable),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        src_valid = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_valid = 4'b0000; out_ready = 1'b1;
        Lib = 4'h0; FD = 4'h0; School = 4'h0; Ribs = 4'h0;
        tick(); tick();
        reset = 1'b0;
        #1;
        vectors++; if (Enable !== 1'b0) begin miscompares++; $display("FAIL reset_en got=%0b exp=0", Enable); end
        vectors++; if (muxOutput !== 4'h0) begin miscompares++; $display("FAIL reset_data got=%h exp=0", muxOutput); end
        vectors++; if (Sel !== 2'b00) begin miscompares++; $display("FAIL reset_sel got=%b exp=00", Sel); end
        vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    endtask

    task automatic test_single_beat();
        reset_dut();
        Lib = 4'hA; out_ready = 1'b1; src_valid = 4'b0001;
        #1;
        vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL single_idle_ready got=%b exp=0000", src_ready); end
        tick();
        vectors++; if (src_ready !== 4'b0001) begin miscompares++; $display("FAIL single_grant_ready got=%b exp=0001", src_ready); end
        tick();
        vectors++; if (Enable !== 1'b1) begin miscompares++; $display("FAIL single_en got=%0b exp=1", Enable); end
        vectors++; if (muxOutput !== 4'hA) begin miscompares++; $display("FAIL single_data got=%h exp=a", muxOutput); end
        vectors++; if (Sel !== 2'b00) begin miscompares++; $display("FAIL single_sel got=%b exp=00", Sel); end
        src_valid = 4'b0000;
        tick(); tick();
        vectors++; if (Enable !== 1'b0) begin miscompares++; $display("FAIL single_drain got=%0b exp=0", Enable); end
    endtask

    task automatic test_round_robin();
        int owners [5];
        logic       exp_en;
        logic [1:0] exp_sel;
`ifdef LIB_PRIORITY_EN
        owners = '{0, 1, 0, 2, 0};
`else
        owners = '{0, 1, 2, 3, 0};
`endif
        reset_dut();
        Lib = 4'h1; FD = 4'h2; School = 4'h3; Ribs = 4'h4;
        out_ready = 1'b1; src_valid = 4'b1111;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 1) begin
                exp_en = 1'b0; exp_sel = 2'b00;
            end else begin
                exp_en  = (((k - 2) % 5) != 4);
                exp_sel = 2'(owners[(k - 2) / 5]);
            end
            vectors++; if (Enable !== exp_en) begin miscompares++; $display("FAIL rr_en k=%0d got=%0b exp=%0b", k, Enable, exp_en); end
            if (exp_en) begin
                vectors++; if (Sel !== exp_sel) begin miscompares++; $display("FAIL rr_sel k=%0d got=%b exp=%b", k, Sel, exp_sel); end
                vectors++; if (muxOutput !== 4'(exp_sel) + 4'h1) begin miscompares++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, muxOutput, 4'(exp_sel) + 4'h1); end
            end
        end
        src_valid = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_backpressure();
        int  sent = 0;
        int  got  = 0;
        logic xf;
        reset_dut();
        FD = 4'h1; out_ready = 1'b1; src_valid = 4'b0010;
        tick();
        vectors++; if (src_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant_ready got=%b exp=0010", src_ready); end
        tick();
        sent = 1; FD = 4'h2;
        vectors++; if (Enable !== 1'b1 || Sel !== 2'b01 || muxOutput !== 4'h1) begin miscompares++; $display("FAIL bp_first en=%0b sel=%b data=%h exp 1/01/1", Enable, Sel, muxOutput); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (Enable !== 1'b1 || Sel !== 2'b01 || muxOutput !== 4'h1) begin miscompares++; $display("FAIL bp_hold i=%0d en=%0b sel=%b data=%h exp 1/01/1", i, Enable, Sel, muxOutput); end
            vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_hold_ready i=%0d got=%b exp=0000", i, src_ready); end
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (Enable && out_ready) begin
                vectors++; if (muxOutput !== 4'(got + 1)) begin miscompares++; $display("FAIL bp_order beat=%0d got=%h exp=%h", got, muxOutput, 4'(got + 1)); end
                got++;
            end
            xf = src_valid[1] && src_ready[1];
            tick();
            if (xf) begin
                sent++;
                FD = 4'(sent + 1);
                if (sent == 4) src_valid = 4'b0000;
            end
        end
        vectors++; if (got !== 4) begin miscompares++; $display("FAIL bp_count got=%0d exp=4", got); end
    endtask

    task automatic test_drop_midburst();
        logic       exp_en  [1:6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] exp_sel [1:6] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3};
        reset_dut();
        School = 4'h6; Ribs = 4'h9; out_ready = 1'b1; src_valid = 4'b1100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++; if (Enable !== exp_en[k]) begin miscompares++; $display("FAIL drop_en k=%0d got=%0b exp=%0b", k, Enable, exp_en[k]); end
            if (exp_en[k]) begin
                vectors++; if (Sel !== exp_sel[k]) begin miscompares++; $display("FAIL drop_sel k=%0d got=%b exp=%b", k, Sel, exp_sel[k]); end
            end
            if (k == 5) begin
                vectors++; if (src_ready !== 4'b1000) begin miscompares++; $display("FAIL drop_ribs_ready got=%b exp=1000", src_ready); end
            end
            if (k == 3) src_valid[2] = 1'b0;
        end
        vectors++; if (muxOutput !== 4'h9) begin miscompares++; $display("FAIL drop_ribs_data got=%h exp=9", muxOutput); end
        src_valid = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midburst();
        reset_dut();
        Ribs = 4'h7; out_ready = 1'b1; src_valid = 4'b1000;
        tick();
        tick();
        vectors++; if (Enable !== 1'b1 || Sel !== 2'b11 || muxOutput !== 4'h7) begin miscompares++; $display("FAIL rstm_beat en=%0b sel=%b data=%h exp 1/11/7", Enable, Sel, muxOutput); end
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        vectors++; if (Enable !== 1'b0) begin miscompares++; $display("FAIL rstm_en got=%0b exp=0", Enable); end
        vectors++; if (Sel !== 2'b00) begin miscompares++; $display("FAIL rstm_sel got=%b exp=00", Sel); end
        vectors++; if (muxOutput !== 4'h0) begin miscompares++; $display("FAIL rstm_data got=%h exp=0", muxOutput); end
        vectors++; if (src_ready !== 4'b0000) begin miscompares++; $display("FAIL rstm_ready got=%b exp=0000", src_ready); end
        reset = 1'b0; Lib = 4'hB; FD = 4'hC; out_ready = 1'b1; src_valid = 4'b0011;
        tick();
        vectors++; if (src_ready !== 4'b0001) begin miscompares++; $display("FAIL rstm_lib_first got=%b exp=0001", src_ready); end
        tick();
        vectors++; if (Enable !== 1'b1 || Sel !== 2'b00 || muxOutput !== 4'hB) begin miscompares++; $display("FAIL rstm_lib_beat en=%0b sel=%b data=%h exp 1/00/b", Enable, Sel, muxOutput); end
        src_valid = 4'b0000;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_backpressure();
        test_drop_midburst();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
